// File: rtl/seq_pattern_gen_if.sv
// Control and serial-stream signals of the pattern generator.
// The master drives requests; the slave (the generator) drives the stream.
interface seq_pattern_gen_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [CNT_W-1:0] repeat_n;
    logic             x;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pattern, repeat_n,
        input  x, valid, busy, done
    );

    modport slave (
        input  start, abort, pattern, repeat_n,
        output x, valid, busy, done
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: emits a latched pattern MSB first, repeat_n times,
// with GAP_CYC idle cycles between repetitions and a one-cycle done pulse.
module seq_pattern_gen #(
    parameter int PAT_W   = 4,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_pattern_gen_if.slave bus
);
    localparam int IDX_W = $clog2(PAT_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
    localparam logic [3:0]       GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           r_state;
    logic [PAT_W-1:0] r_pattern;
    logic [PAT_W-1:0] r_shift;
    logic [CNT_W-1:0] r_rep_cnt;
    logic [IDX_W-1:0] r_bit_idx;
    logic [3:0]       r_gap_cnt;
    logic             r_x;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    // Outputs default to the quiet level each cycle; states override them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pattern <= '0;
            r_shift   <= '0;
            r_rep_cnt <= '0;
            r_bit_idx <= '0;
            r_gap_cnt <= '0;
            r_x       <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_x     <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (bus.repeat_n != '0) begin
                            r_pattern <= bus.pattern;
                            r_rep_cnt <= bus.repeat_n;
                            r_shift   <= {bus.pattern[PAT_W-2:0], 1'b0};
                            r_bit_idx <= '0;
                            r_x       <= bus.pattern[PAT_W-1];
                            r_valid   <= 1'b1;
                            r_busy    <= 1'b1;
                            r_state   <= SHIFT;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (r_bit_idx == LAST_IDX) begin
                        // r_rep_cnt counts repetitions still owed, including this one.
                        if (r_rep_cnt <= CNT_W'(1)) begin
                            r_rep_cnt <= '0;
                            r_done    <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_rep_cnt <= r_rep_cnt - CNT_W'(1);
                            if (GAP_CYC == 0) begin
                                r_shift   <= {r_pattern[PAT_W-2:0], 1'b0};
                                r_bit_idx <= '0;
                                r_x       <= r_pattern[PAT_W-1];
                                r_valid   <= 1'b1;
                                r_busy    <= 1'b1;
                            end else begin
                                r_gap_cnt <= GAP_LOAD;
                                r_busy    <= 1'b1;
                                r_state   <= GAP;
                            end
                        end
                    end else begin
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                        r_x       <= r_shift[PAT_W-1];
                        r_shift   <= {r_shift[PAT_W-2:0], 1'b0};
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                GAP: begin
                    if (bus.abort) begin
                        r_state <= IDLE;
                    end else if (r_gap_cnt == 4'd0) begin
                        r_shift   <= {r_pattern[PAT_W-2:0], 1'b0};
                        r_bit_idx <= '0;
                        r_x       <= r_pattern[PAT_W-1];
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                        r_busy    <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.x     = r_x;
    assign bus.valid = r_valid;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: the stimulus side predicts every active
// output cycle into a queue, a negedge monitor pops and compares.
module tb_seq_pattern_gen;
    localparam int PAT_W   = 4;
    localparam int CNT_W   = 4;
    localparam int GAP_CYC = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_if ();

    seq_pattern_gen #(
        .PAT_W  (PAT_W),
        .CNT_W  (CNT_W),
        .GAP_CYC(GAP_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    typedef struct {
        int   cyc;
        logic x;
        logic valid;
        logic busy;
        logic done;
    } item_t;

    item_t exp_q[$];
    int    cyc       = 0;
    int    n_assert  = 0;
    int    n_fail    = 0;
    int    free_cyc  = 0;
    int    busy_from = 1;
    int    busy_to   = 0;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_assert++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic void push(input int c, input logic x, input logic v,
                                 input logic b, input logic d);
        item_t it;
        it.cyc = c; it.x = x; it.valid = v; it.busy = b; it.done = d;
        exp_q.push_back(it);
    endfunction

    // Reference: a start accepted in cycle s produces this cycle-stamped trace.
    function automatic void model_gen(input int s, input logic [PAT_W-1:0] p, input int n);
        int t;
        t = s + 1;
        if (n == 0) begin
            push(t, 1'b0, 1'b0, 1'b0, 1'b1);
            free_cyc  = t + 1;
            busy_from = 1;
            busy_to   = 0;
            return;
        end
        busy_from = t;
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < PAT_W; i++) begin
                push(t, p[PAT_W-1-i], 1'b1, 1'b1, 1'b0);
                t++;
            end
            if (r < n - 1) begin
                for (int g = 0; g < GAP_CYC; g++) begin
                    push(t, 1'b0, 1'b0, 1'b1, 1'b0);
                    t++;
                end
            end
        end
        busy_to = t - 1;
        push(t, 1'b0, 1'b0, 1'b0, 1'b1);
        free_cyc = t + 1;
    endfunction

    task automatic drive(input logic s, input logic a,
                         input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] n);
        @(posedge clk);
        #1;
        bus_if.start    = s;
        bus_if.abort    = a;
        bus_if.pattern  = p;
        bus_if.repeat_n = n;
        if (a && cyc >= busy_from && cyc <= busy_to) begin
            while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc)
                exp_q.delete(exp_q.size() - 1);
            free_cyc  = cyc + 1;
            busy_from = 1;
            busy_to   = 0;
        end else if (s && !a && cyc >= free_cyc) begin
            model_gen(cyc, p, int'(n));
        end
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            drive(1'b0, 1'b0, PAT_W'($urandom), CNT_W'($urandom));
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_async_x",     {31'd0, bus_if.x},     32'd0);
        chk("rst_async_valid", {31'd0, bus_if.valid}, 32'd0);
        chk("rst_async_busy",  {31'd0, bus_if.busy},  32'd0);
        chk("rst_async_done",  {31'd0, bus_if.done},  32'd0);
        free_cyc  = 0;
        busy_from = 1;
        busy_to   = 0;
        bus_if.start = 1'b0;
        bus_if.abort = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every active output cycle must match the head of the queue.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_if.valid || bus_if.busy || bus_if.done) begin
                    n_assert++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output at cycle %0d: got valid=%0b busy=%0b done=%0b, expected all 0",
                                 cyc, bus_if.valid, bus_if.busy, bus_if.done);
                    end else begin
                        it = exp_q.pop_front();
                        chk("out_cycle", cyc, it.cyc);
                        chk("out_x",     {31'd0, bus_if.x},     {31'd0, it.x});
                        chk("out_valid", {31'd0, bus_if.valid}, {31'd0, it.valid});
                        chk("out_busy",  {31'd0, bus_if.busy},  {31'd0, it.busy});
                        chk("out_done",  {31'd0, bus_if.done},  {31'd0, it.done});
                    end
                end else begin
                    chk("idle_x", {31'd0, bus_if.x}, 32'd0);
                    n_assert++;
                    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                        n_fail++;
                        $display("FAIL missing_output at cycle %0d: got idle, expected item for cycle %0d",
                                 cyc, exp_q[0].cyc);
                    end
                end
            end
        end
    end

    initial begin
        logic s, a;
        bus_if.start    = 1'b0;
        bus_if.abort    = 1'b0;
        bus_if.pattern  = '0;
        bus_if.repeat_n = '0;
        #1;
        chk("reset_x",     {31'd0, bus_if.x},     32'd0);
        chk("reset_valid", {31'd0, bus_if.valid}, 32'd0);
        chk("reset_busy",  {31'd0, bus_if.busy},  32'd0);
        chk("reset_done",  {31'd0, bus_if.done},  32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // single repetition
        drive(1'b1, 1'b0, 4'b1010, 4'd1);
        idle(6);
        // three repetitions with gaps
        drive(1'b1, 1'b0, 4'b1101, 4'd3);
        idle(16);
        // zero repetitions
        drive(1'b1, 1'b0, 4'b1111, 4'd0);
        idle(3);
        // start re-pulsed while busy is ignored
        drive(1'b1, 1'b0, 4'b1010, 4'd1);
        drive(1'b0, 1'b0, 4'b1010, 4'd1);
        drive(1'b1, 1'b0, 4'b0110, 4'd3);
        idle(6);
        // abort in cycle 3, new start in cycle 6
        drive(1'b1, 1'b0, 4'b1010, 4'd1);
        idle(2);
        drive(1'b0, 1'b1, 4'b1010, 4'd1);
        idle(2);
        drive(1'b1, 1'b0, 4'b1100, 4'd2);
        idle(12);
        // abort together with start in IDLE
        drive(1'b1, 1'b1, 4'b1011, 4'd2);
        idle(3);
        // asynchronous reset mid-bit
        drive(1'b1, 1'b0, 4'b1010, 4'd2);
        idle(1);
        reset_mid();
        idle(8);

        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(3) == 0);
            a = ($urandom_range(24) == 0);
            if ($urandom_range(15) == 0)
                drive(s, a, PAT_W'($urandom), CNT_W'($urandom));
            else
                drive(s, a, PAT_W'($urandom), CNT_W'($urandom_range(3)));
        end

        for (int k = 0; k < 300 && exp_q.size() > 0; k++)
            idle(1);
        chk("queue_drained", exp_q.size(), 32'd0);
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 4, giving the serial pattern length in bits (legal range 2..16).
REQ-002 SHALL have parameter CNT_W, default 4, giving the width of the repetition count.
REQ-003 SHALL have parameter GAP_CYC, default 1, giving the idle cycles between repetitions (legal range 0..15).
REQ-004 SHALL have one clock and an asynchronous active-low reset: `clk  input  1  rising-edge clock for all state`.
REQ-005 SHALL have `rst_n  input  1  asynchronous active-low reset`.
REQ-006 SHALL have `start  input  1  request to transmit, sampled only in IDLE`.
REQ-007 SHALL have `abort  input  1  synchronous stop of an active transmission`.
REQ-008 SHALL have `pattern  input  PAT_W  bits to emit, MSB first, latched on accepted start`.
REQ-009 SHALL have `repeat_n  input  CNT_W  number of pattern repetitions, latched on accepted start`.
REQ-010 SHALL have `x  output  1  serial bit stream, registered (detector-side input)`.
REQ-011 SHALL have `valid  output  1  x carries a pattern bit this cycle`.
REQ-012 SHALL have `busy  output  1  transmission in progress`.
REQ-013 SHALL have `done  output  1  one-cycle pulse after the last bit of the last repetition`.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, GAP and DONE, with all outputs driven from registers.
REQ-015 In IDLE with start=1, abort=0 and repeat_n!=0, the block SHALL latch pattern and repeat_n and enter SHIFT, so the first bit appears on x in the next cycle.
REQ-016 In IDLE with start=1 and repeat_n=0, the block SHALL enter DONE without asserting valid.
REQ-017 In SHIFT, the block SHALL present x=pattern[PAT_W-1-i] with valid=1 for bit index i=0..PAT_W-1, one bit per cycle.
REQ-018 After bit PAT_W-1, if repetitions remain, the block SHALL enter GAP for GAP_CYC cycles; if GAP_CYC=0 it SHALL go directly to SHIFT with no bubble.
REQ-019 After bit PAT_W-1 of the final repetition, the block SHALL enter DONE.
REQ-020 In GAP, the block SHALL drive x=0, valid=0 and busy=1, and SHALL return to SHIFT with the bit index at 0.
REQ-021 In DONE, the block SHALL drive done=1, busy=0, valid=0 and x=0 for exactly one cycle, then enter IDLE.
REQ-022 busy SHALL be 1 in SHIFT and GAP only.
REQ-023 The repetition counter SHALL be a CNT_W-bit down-counter decremented at the end of each repetition, with DONE entered when it reaches 0; it SHALL never wrap.
REQ-024 The bit index counter SHALL use clog2(PAT_W) bits and SHALL reset to 0 at the start of every repetition.
REQ-025 start asserted outside IDLE (SHIFT, GAP or DONE) SHALL be ignored, with no queuing.
REQ-026 Changes on pattern and repeat_n while busy=1 SHALL have no effect on the stream in progress.
REQ-027 abort=1 in SHIFT or GAP SHALL move the block to IDLE on the next edge, with x=0, valid=0, busy=0 and no done pulse.
REQ-028 abort=1 in IDLE SHALL take priority over a simultaneous start, so that start is not accepted.
REQ-029 abort=1 in DONE SHALL have no effect: the done pulse completes.
REQ-030 In IDLE, the block SHALL drive x=0, valid=0, busy=0 and done=0.

Reset
REQ-031 rst_n=0 SHALL immediately force state=IDLE and x=0, valid=0, busy=0, done=0, and clear all counters and latched registers, independent of clk.
REQ-032 Reset asserted mid-transmission SHALL discard the transmission; after release, the block SHALL wait in IDLE for a new start.
REQ-033 The block SHALL first sample start on the first rising clk edge after rst_n deasserts.

Verification
REQ-034 Start at cycle 0 with pattern=4'b1010, repeat_n=1 -> x=1,0,1,0 with valid=1 in cycles 1-4; done=1 in cycle 5; busy=0 in cycle 5.
REQ-035 pattern=4'b1101, repeat_n=3, GAP_CYC=1 -> bits in cycles 1-4, 6-9 and 11-14, valid=0 in cycles 5 and 10, done in cycle 15.
REQ-036 repeat_n=0 with start -> done in cycle 1; valid never asserts; busy stays 0.
REQ-037 start re-pulsed in cycle 2 with a different pattern during the REQ-034 run -> stream unchanged; done still in cycle 5 only.
REQ-038 abort in cycle 3 of the REQ-034 run -> valid=0 and busy=0 from cycle 4; no done pulse; a new start in cycle 6 is accepted.
REQ-039 rst_n pulled low mid-bit in cycle 2 -> outputs go to 0 asynchronously; after release, x stays 0 until a new start.
